// File: rtl/tl_coupler_buffered.sv
// TileLink-UL coupler with an independently sized FIFO on the A and D channels,
// an A-side quiesce control, and occupancy/idle reporting. Depth 0 means wire-through.

module tl_coupler_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          block,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] count
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset;
            // block gates both directions so nothing crosses while held
            assign in_ready  = out_ready && !block;
            assign out_valid = in_valid && !block;
            assign out_data  = in_data;
            assign count     = '0;
        end else begin : g_fifo
            localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
            localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

            logic [W-1:0]  mem [DEPTH];
            logic [PW-1:0] wr_ptr;
            logic [PW-1:0] rd_ptr;
            logic [CW-1:0] cnt;
            logic          enq;
            logic          deq;

            // ready looks only at the registered count: no fall-through when full
            assign in_ready  = (cnt != CW'(DEPTH)) && !block;
            assign out_valid = (cnt != '0);
            assign enq       = in_valid && in_ready;
            assign deq       = out_valid && out_ready;
            assign out_data  = mem[rd_ptr];
            assign count     = cnt;

            always_ff @(posedge clock) begin
                if (reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (enq) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                    if (deq) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                    if (enq && !deq)      cnt <= cnt + 1'b1;
                    else if (deq && !enq) cnt <= cnt - 1'b1;
                end
            end

            always_ff @(posedge clock) begin
                if (enq) mem[wr_ptr] <= in_data;
            end
        end
    endgenerate
endmodule

module tl_coupler_buffered #(
    parameter int ADDR_W   = 31,
    parameter int DATA_W   = 64,
    parameter int SIZE_W   = 4,
    parameter int SOURCE_W = 1,
    parameter int SINK_W   = 1,
    parameter int A_DEPTH  = 2,
    parameter int D_DEPTH  = 2,
    localparam int CW_A    = (A_DEPTH > 0) ? $clog2(A_DEPTH + 1) : 1,
    localparam int CW_D    = (D_DEPTH > 0) ? $clog2(D_DEPTH + 1) : 1
) (
    input  logic                clock,
    input  logic                reset,
    output logic                auto_tl_in_a_ready,
    input  logic                auto_tl_in_a_valid,
    input  logic [2:0]          auto_tl_in_a_bits_opcode,
    input  logic [2:0]          auto_tl_in_a_bits_param,
    input  logic [SIZE_W-1:0]   auto_tl_in_a_bits_size,
    input  logic [SOURCE_W-1:0] auto_tl_in_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_tl_in_a_bits_address,
    input  logic [DATA_W/8-1:0] auto_tl_in_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_tl_in_a_bits_data,
    input  logic                auto_tl_in_a_bits_corrupt,
    input  logic                auto_tl_in_d_ready,
    output logic                auto_tl_in_d_valid,
    output logic [2:0]          auto_tl_in_d_bits_opcode,
    output logic [1:0]          auto_tl_in_d_bits_param,
    output logic [SIZE_W-1:0]   auto_tl_in_d_bits_size,
    output logic [SOURCE_W-1:0] auto_tl_in_d_bits_source,
    output logic [SINK_W-1:0]   auto_tl_in_d_bits_sink,
    output logic                auto_tl_in_d_bits_denied,
    output logic [DATA_W-1:0]   auto_tl_in_d_bits_data,
    output logic                auto_tl_in_d_bits_corrupt,
    input  logic                auto_tl_out_a_ready,
    output logic                auto_tl_out_a_valid,
    output logic [2:0]          auto_tl_out_a_bits_opcode,
    output logic [2:0]          auto_tl_out_a_bits_param,
    output logic [SIZE_W-1:0]   auto_tl_out_a_bits_size,
    output logic [SOURCE_W-1:0] auto_tl_out_a_bits_source,
    output logic [ADDR_W-1:0]   auto_tl_out_a_bits_address,
    output logic [DATA_W/8-1:0] auto_tl_out_a_bits_mask,
    output logic [DATA_W-1:0]   auto_tl_out_a_bits_data,
    output logic                auto_tl_out_a_bits_corrupt,
    output logic                auto_tl_out_d_ready,
    input  logic                auto_tl_out_d_valid,
    input  logic [2:0]          auto_tl_out_d_bits_opcode,
    input  logic [1:0]          auto_tl_out_d_bits_param,
    input  logic [SIZE_W-1:0]   auto_tl_out_d_bits_size,
    input  logic [SOURCE_W-1:0] auto_tl_out_d_bits_source,
    input  logic [SINK_W-1:0]   auto_tl_out_d_bits_sink,
    input  logic                auto_tl_out_d_bits_denied,
    input  logic [DATA_W-1:0]   auto_tl_out_d_bits_data,
    input  logic                auto_tl_out_d_bits_corrupt,
    input  logic                quiesce,
    output logic [CW_A-1:0]     a_count,
    output logic [CW_D-1:0]     d_count,
    output logic                idle
);
    localparam int AW = 3 + 3 + SIZE_W + SOURCE_W + ADDR_W + DATA_W / 8 + DATA_W + 1;
    localparam int DW = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1;

    logic [AW-1:0] a_enq;
    logic [AW-1:0] a_deq;
    logic [DW-1:0] d_enq;
    logic [DW-1:0] d_deq;

    assign a_enq = {auto_tl_in_a_bits_opcode, auto_tl_in_a_bits_param, auto_tl_in_a_bits_size,
                    auto_tl_in_a_bits_source, auto_tl_in_a_bits_address, auto_tl_in_a_bits_mask,
                    auto_tl_in_a_bits_data, auto_tl_in_a_bits_corrupt};
    assign {auto_tl_out_a_bits_opcode, auto_tl_out_a_bits_param, auto_tl_out_a_bits_size,
            auto_tl_out_a_bits_source, auto_tl_out_a_bits_address, auto_tl_out_a_bits_mask,
            auto_tl_out_a_bits_data, auto_tl_out_a_bits_corrupt} = a_deq;

    assign d_enq = {auto_tl_out_d_bits_opcode, auto_tl_out_d_bits_param, auto_tl_out_d_bits_size,
                    auto_tl_out_d_bits_source, auto_tl_out_d_bits_sink, auto_tl_out_d_bits_denied,
                    auto_tl_out_d_bits_data, auto_tl_out_d_bits_corrupt};
    assign {auto_tl_in_d_bits_opcode, auto_tl_in_d_bits_param, auto_tl_in_d_bits_size,
            auto_tl_in_d_bits_source, auto_tl_in_d_bits_sink, auto_tl_in_d_bits_denied,
            auto_tl_in_d_bits_data, auto_tl_in_d_bits_corrupt} = d_deq;

    tl_coupler_fifo #(.W(AW), .DEPTH(A_DEPTH), .CW(CW_A)) u_a_fifo (
        .clock     (clock),
        .reset     (reset),
        .block     (quiesce),
        .in_valid  (auto_tl_in_a_valid),
        .in_ready  (auto_tl_in_a_ready),
        .in_data   (a_enq),
        .out_valid (auto_tl_out_a_valid),
        .out_ready (auto_tl_out_a_ready),
        .out_data  (a_deq),
        .count     (a_count)
    );

    // responses must always drain, so quiesce never reaches the D channel
    tl_coupler_fifo #(.W(DW), .DEPTH(D_DEPTH), .CW(CW_D)) u_d_fifo (
        .clock     (clock),
        .reset     (reset),
        .block     (1'b0),
        .in_valid  (auto_tl_out_d_valid),
        .in_ready  (auto_tl_out_d_ready),
        .in_data   (d_enq),
        .out_valid (auto_tl_in_d_valid),
        .out_ready (auto_tl_in_d_ready),
        .out_data  (d_deq),
        .count     (d_count)
    );

    assign idle = (a_count == '0) && (d_count == '0) && !auto_tl_in_a_valid && !auto_tl_out_d_valid;
endmodule

// File: tb/tb_tl_coupler_buffered.sv
// Randomised and directed bench for tl_coupler_buffered: a depth-2 instance checked against
// queue-based channel models, plus a depth-0 instance checked for same-cycle wire-through.

module tb_tl_coupler_buffered;
    localparam int AW = 115;
    localparam int DW = 77;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic quiesce = 1'b0;
    logic in_a_valid = 1'b0, out_a_ready = 1'b0, out_d_valid = 1'b0, in_d_ready = 1'b0;
    logic [AW-1:0] a_in = '0;
    logic [DW-1:0] d_dn = '0;

    logic in_a_ready, out_a_valid, out_d_ready, in_d_valid, idle;
    logic [AW-1:0] a_out;
    logic [DW-1:0] d_up;
    logic [1:0] a_count, d_count;

    logic p_in_a_ready, p_out_a_valid, p_out_d_ready, p_in_d_valid, p_idle;
    logic [AW-1:0] p_a_out;
    logic [DW-1:0] p_d_up;
    logic [0:0] p_a_count, p_d_count;

    logic [AW-1:0] a_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    tl_coupler_buffered dut (
        .clock(clock), .reset(reset),
        .auto_tl_in_a_ready(in_a_ready), .auto_tl_in_a_valid(in_a_valid),
        .auto_tl_in_a_bits_opcode(a_in[114:112]), .auto_tl_in_a_bits_param(a_in[111:109]),
        .auto_tl_in_a_bits_size(a_in[108:105]), .auto_tl_in_a_bits_source(a_in[104:104]),
        .auto_tl_in_a_bits_address(a_in[103:73]), .auto_tl_in_a_bits_mask(a_in[72:65]),
        .auto_tl_in_a_bits_data(a_in[64:1]), .auto_tl_in_a_bits_corrupt(a_in[0]),
        .auto_tl_in_d_ready(in_d_ready), .auto_tl_in_d_valid(in_d_valid),
        .auto_tl_in_d_bits_opcode(d_up[76:74]), .auto_tl_in_d_bits_param(d_up[73:72]),
        .auto_tl_in_d_bits_size(d_up[71:68]), .auto_tl_in_d_bits_source(d_up[67:67]),
        .auto_tl_in_d_bits_sink(d_up[66:66]), .auto_tl_in_d_bits_denied(d_up[65]),
        .auto_tl_in_d_bits_data(d_up[64:1]), .auto_tl_in_d_bits_corrupt(d_up[0]),
        .auto_tl_out_a_ready(out_a_ready), .auto_tl_out_a_valid(out_a_valid),
        .auto_tl_out_a_bits_opcode(a_out[114:112]), .auto_tl_out_a_bits_param(a_out[111:109]),
        .auto_tl_out_a_bits_size(a_out[108:105]), .auto_tl_out_a_bits_source(a_out[104:104]),
        .auto_tl_out_a_bits_address(a_out[103:73]), .auto_tl_out_a_bits_mask(a_out[72:65]),
        .auto_tl_out_a_bits_data(a_out[64:1]), .auto_tl_out_a_bits_corrupt(a_out[0]),
        .auto_tl_out_d_ready(out_d_ready), .auto_tl_out_d_valid(out_d_valid),
        .auto_tl_out_d_bits_opcode(d_dn[76:74]), .auto_tl_out_d_bits_param(d_dn[73:72]),
        .auto_tl_out_d_bits_size(d_dn[71:68]), .auto_tl_out_d_bits_source(d_dn[67:67]),
        .auto_tl_out_d_bits_sink(d_dn[66:66]), .auto_tl_out_d_bits_denied(d_dn[65]),
        .auto_tl_out_d_bits_data(d_dn[64:1]), .auto_tl_out_d_bits_corrupt(d_dn[0]),
        .quiesce(quiesce), .a_count(a_count), .d_count(d_count), .idle(idle)
    );

    tl_coupler_buffered #(.A_DEPTH(0), .D_DEPTH(0)) dut_pass (
        .clock(clock), .reset(reset),
        .auto_tl_in_a_ready(p_in_a_ready), .auto_tl_in_a_valid(in_a_valid),
        .auto_tl_in_a_bits_opcode(a_in[114:112]), .auto_tl_in_a_bits_param(a_in[111:109]),
        .auto_tl_in_a_bits_size(a_in[108:105]), .auto_tl_in_a_bits_source(a_in[104:104]),
        .auto_tl_in_a_bits_address(a_in[103:73]), .auto_tl_in_a_bits_mask(a_in[72:65]),
        .auto_tl_in_a_bits_data(a_in[64:1]), .auto_tl_in_a_bits_corrupt(a_in[0]),
        .auto_tl_in_d_ready(in_d_ready), .auto_tl_in_d_valid(p_in_d_valid),
        .auto_tl_in_d_bits_opcode(p_d_up[76:74]), .auto_tl_in_d_bits_param(p_d_up[73:72]),
        .auto_tl_in_d_bits_size(p_d_up[71:68]), .auto_tl_in_d_bits_source(p_d_up[67:67]),
        .auto_tl_in_d_bits_sink(p_d_up[66:66]), .auto_tl_in_d_bits_denied(p_d_up[65]),
        .auto_tl_in_d_bits_data(p_d_up[64:1]), .auto_tl_in_d_bits_corrupt(p_d_up[0]),
        .auto_tl_out_a_ready(out_a_ready), .auto_tl_out_a_valid(p_out_a_valid),
        .auto_tl_out_a_bits_opcode(p_a_out[114:112]), .auto_tl_out_a_bits_param(p_a_out[111:109]),
        .auto_tl_out_a_bits_size(p_a_out[108:105]), .auto_tl_out_a_bits_source(p_a_out[104:104]),
        .auto_tl_out_a_bits_address(p_a_out[103:73]), .auto_tl_out_a_bits_mask(p_a_out[72:65]),
        .auto_tl_out_a_bits_data(p_a_out[64:1]), .auto_tl_out_a_bits_corrupt(p_a_out[0]),
        .auto_tl_out_d_ready(p_out_d_ready), .auto_tl_out_d_valid(out_d_valid),
        .auto_tl_out_d_bits_opcode(d_dn[76:74]), .auto_tl_out_d_bits_param(d_dn[73:72]),
        .auto_tl_out_d_bits_size(d_dn[71:68]), .auto_tl_out_d_bits_source(d_dn[67:67]),
        .auto_tl_out_d_bits_sink(d_dn[66:66]), .auto_tl_out_d_bits_denied(d_dn[65]),
        .auto_tl_out_d_bits_data(d_dn[64:1]), .auto_tl_out_d_bits_corrupt(d_dn[0]),
        .quiesce(quiesce), .a_count(p_a_count), .d_count(p_d_count), .idle(p_idle)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] rand_a();
        logic [127:0] r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_d();
        logic [127:0] r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // One clock: compare outputs mid-cycle against the channel queues, then advance the queues.
    task automatic step(output bit a_fire);
        int as, ds;
        bit a_pop, d_fire, d_pop;
        @(negedge clock);
        as = a_exp_q.size();
        ds = d_exp_q.size();
        check("a_count", a_count, as);
        check("d_count", d_count, ds);
        check("in_a_ready", in_a_ready, (as < 2) && !quiesce);
        check("out_a_valid", out_a_valid, as != 0);
        if (as != 0) check("out_a_bits", a_out, a_exp_q[0]);
        check("out_d_ready", out_d_ready, ds < 2);
        check("in_d_valid", in_d_valid, ds != 0);
        if (ds != 0) check("in_d_bits", d_up, d_exp_q[0]);
        check("idle", idle, (as == 0) && (ds == 0) && !in_a_valid && !out_d_valid);
        check("p_a_ready", p_in_a_ready, out_a_ready && !quiesce);
        check("p_a_valid", p_out_a_valid, in_a_valid && !quiesce);
        check("p_a_bits", p_a_out, a_in);
        check("p_d_ready", p_out_d_ready, in_d_ready);
        check("p_d_valid", p_in_d_valid, out_d_valid);
        check("p_d_bits", p_d_up, d_dn);
        check("p_counts", {p_a_count, p_d_count}, 2'b00);
        @(posedge clock);
        a_fire = 0;
        if (reset) begin
            a_exp_q.delete();
            d_exp_q.delete();
        end else begin
            a_fire = in_a_valid && (as < 2) && !quiesce;
            a_pop  = (as != 0) && out_a_ready;
            d_fire = out_d_valid && (ds < 2);
            d_pop  = (ds != 0) && in_d_ready;
            if (a_pop) void'(a_exp_q.pop_front());
            if (a_fire) a_exp_q.push_back(a_in);
            if (d_pop) void'(d_exp_q.pop_front());
            if (d_fire) d_exp_q.push_back(d_dn);
        end
        #1;
    endtask

    initial begin
        bit f;
        bit got;
        @(posedge clock);
        #1;
        step(f);
        reset = 1'b0;
        step(f);
        check("rst_a_count", a_count, 0);
        check("rst_in_a_ready", in_a_ready, 1);
        check("rst_in_d_valid", in_d_valid, 0);

        // single beat, one-cycle latency through an empty FIFO
        out_a_ready = 1'b1;
        in_d_ready = 1'b1;
        a_in = rand_a();
        a_in[103:73] = 31'h1000_0000;
        a_in[64:1] = 64'h0000_0000_DEAD_BEEF;
        in_a_valid = 1'b1;
        step(f);
        in_a_valid = 1'b0;
        check("tp1_valid", out_a_valid, 1);
        check("tp1_addr", a_out[103:73], 31'h1000_0000);
        check("tp1_data", a_out[64:1], 64'hDEAD_BEEF);
        check("tp1_count1", a_count, 1);
        step(f);
        check("tp1_count0", a_count, 0);

        // backpressure: two accepted, third held until space frees
        out_a_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_in = rand_a();
            in_a_valid = 1'b1;
            step(f);
        end
        check("bp_full_ready", in_a_ready, 0);
        check("bp_full_count", a_count, 2);
        out_a_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step(f);
            got = f;
        end
        check("bp_third_accepted", got, 1);

        // full FIFO with both sides busy
        in_a_valid = 1'b1;
        out_a_ready = 1'b0;
        step(f);
        step(f);
        out_a_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(f);
            if (f) a_in = rand_a();
        end
        in_a_valid = 1'b0;
        repeat (3) step(f);

        // quiesce with one beat buffered
        out_a_ready = 1'b0;
        a_in = rand_a();
        in_a_valid = 1'b1;
        step(f);
        quiesce = 1'b1;
        #1;
        check("q_ready_now", in_a_ready, 0);
        step(f);
        out_a_ready = 1'b1;
        step(f);
        in_a_valid = 1'b0;
        step(f);
        check("q_idle", idle, 1);
        quiesce = 1'b0;
        step(f);

        // reset drops buffered D beats
        in_d_ready = 1'b0;
        out_d_valid = 1'b1;
        d_dn = rand_d();
        step(f);
        d_dn = rand_d();
        step(f);
        out_d_valid = 1'b0;
        check("d_full_count", d_count, 2);
        reset = 1'b1;
        step(f);
        reset = 1'b0;
        check("rst_d_valid", in_d_valid, 0);
        check("rst_d_count", d_count, 0);
        in_d_ready = 1'b1;
        repeat (3) step(f);

        for (int k = 0; k < 2000; k++) begin
            in_a_valid  = ($urandom_range(0, 3) != 0);
            a_in        = rand_a();
            out_a_ready = ($urandom_range(0, 2) != 0);
            quiesce     = ($urandom_range(0, 9) == 0);
            out_d_valid = ($urandom_range(0, 2) != 0);
            d_dn        = rand_d();
            in_d_ready  = ($urandom_range(0, 2) != 0);
            reset       = ($urandom_range(0, 199) == 0);
            step(f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
